obi_port_arbiter: RTL and testbench

- Shares one OBI-style memory port (req/gnt/rvalid, in-order responses) between the core instruction-fetch port (read-only) and the core data port.
- Sits between the core top and a single-ported RAM/bus slave.
- Arbitrates requests round-robin and locks the selection until the request is granted.
- Tracks outstanding transactions in an owner FIFO so each in-order response is routed back to the port that issued it.

---
 rtl/obi_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_obi_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_port_arbiter.sv
// Shares one OBI memory port between the instruction-fetch and data ports.
// Round-robin arbitration with grant lock; an owner FIFO routes in-order responses back.
module obi_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      instr_req_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
    output logic [DATA_WIDTH-1:0]     instr_rdata_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      proto_err_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_q, lock_d;
    port_e                      lock_owner_q, lock_owner_d;
    port_e                      rr_last_q, rr_last_d;
    logic                       proto_err_q, proto_err_d;
    port_e                      sel_s, head_s;
    logic                       lock_live_s, not_full_s, push_s, pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A lock only survives while its owner keeps requesting.
    assign lock_live_s = lock_q & ((lock_owner_q == PORT_INSTR) ? instr_req_i : data_req_i);
    assign not_full_s  = (count_q < CNT_W'(MAX_OUTSTANDING));
    assign mem_req_o   = rst_ni & (instr_req_i | data_req_i) & not_full_s;
    assign push_s      = mem_req_o & mem_gnt_i;
    assign pop_s       = rst_ni & mem_rvalid_i & (count_q != CNT_W'(0));
    assign head_s      = port_e'(owner_q[rptr_q]);

    assign instr_gnt_o    = push_s & (sel_s == PORT_INSTR);
    assign data_gnt_o     = push_s & (sel_s == PORT_DATA);
    assign instr_rvalid_o = pop_s & (head_s == PORT_INSTR);
    assign data_rvalid_o  = pop_s & (head_s == PORT_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign proto_err_o    = proto_err_q;

    // Port selection: lock, then single requester, then round-robin.
    always_comb begin
        sel_s = PORT_INSTR;
        if (lock_live_s) begin
            sel_s = lock_owner_q;
        end else if (instr_req_i && !data_req_i) begin
            sel_s = PORT_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel_s = PORT_DATA;
        end else if (rr_last_q == PORT_INSTR) begin
            sel_s = PORT_DATA;
        end else begin
            sel_s = PORT_INSTR;
        end
    end

    // Request payload mux; fetches are full-word reads.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = {BE_W{1'b1}};
        mem_we_o    = 1'b0;
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        case (sel_s)
            PORT_DATA: begin
                mem_addr_o  = data_addr_i;
                mem_be_o    = data_be_i;
                mem_we_o    = data_we_i;
                mem_wdata_o = data_wdata_i;
            end
            default: begin
                mem_addr_o  = instr_addr_i;
                mem_be_o    = {BE_W{1'b1}};
                mem_we_o    = 1'b0;
                mem_wdata_o = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Next-state for owner FIFO, lock, round-robin pointer and error flag.
    always_comb begin
        owner_d      = owner_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        rr_last_d    = rr_last_q;
        lock_d       = mem_req_o & ~mem_gnt_i;
        lock_owner_d = sel_s;
        proto_err_d  = proto_err_q | (mem_rvalid_i & (count_q == CNT_W'(0)));
        if (push_s) begin
            owner_d[wptr_q] = sel_s;
            wptr_d          = ptr_inc(wptr_q);
            rr_last_d       = sel_s;
        end else begin
            wptr_d    = wptr_q;
            rr_last_d = rr_last_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q      <= {MAX_OUTSTANDING{1'b0}};
            wptr_q       <= {PTR_W{1'b0}};
            rptr_q       <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            lock_q       <= 1'b0;
            lock_owner_q <= PORT_INSTR;
            rr_last_q    <= PORT_INSTR;
            proto_err_q  <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rr_last_q    <= rr_last_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_obi_port_arbiter.sv
// Directed bench for obi_port_arbiter: reset, routing, round-robin, lock, full, wrap, protocol error.
module tb_obi_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o;
    logic [31:0] data_addr_i;
    logic [3:0]  data_be_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        proto_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    obi_port_arbiter #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_addr_i(data_addr_i), .data_be_i(data_be_i), .data_we_i(data_we_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Apply inputs for one cycle and let combinational outputs settle.
    task automatic drive(input logic ireq, input logic dreq, input logic gnt, input logic rv);
        instr_req_i  = ireq;
        data_req_i   = dreq;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        #1;
    endtask

    initial begin
        logic [9:0] pat;
        logic       prev;
        logic       p;
        rst_ni = 1'b0;
        instr_addr_i = 32'h0000_0100; data_addr_i = 32'h0000_0300;
        data_be_i = 4'b0011; data_we_i = 1'b1; data_wdata_i = 32'h1122_3344;
        mem_rdata_i = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // Outputs quiet during reset even with all inputs active
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_igth", {31'd0, instr_gnt_o}, 32'd0);
        chk("rst_dgnt", {31'd0, data_gnt_o}, 32'd0);
        chk("rst_irv", {31'd0, instr_rvalid_o}, 32'd0);
        chk("rst_drv", {31'd0, data_rvalid_o}, 32'd0);
        tick();
        chk("rst_perr", {31'd0, proto_err_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Single fetch
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("f_igrant", {31'd0, instr_gnt_o}, 32'd1);
        chk("f_dgrant", {31'd0, data_gnt_o}, 32'd0);
        chk("f_addr", mem_addr_o, 32'h100);
        chk("f_be", {28'd0, mem_be_o}, 32'hF);
        chk("f_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        mem_rdata_i = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f_irv", {31'd0, instr_rvalid_o}, 32'd1);
        chk("f_irdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("f_drv", {31'd0, data_rvalid_o}, 32'd0);
        chk("f_drdata", data_rdata_o, 32'hDEAD_BEEF);
        tick();

        // Round-robin D,I,D,I with immediate responses
        instr_addr_i = 32'h0000_0200;
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, k < 4, 1'b1, k > 0);
            if (k < 4) begin
                chk("rr_dgnt", {31'd0, data_gnt_o}, {31'd0, (k % 2) == 0});
                chk("rr_igrant", {31'd0, instr_gnt_o}, {31'd0, (k % 2) == 1});
                chk("rr_addr", mem_addr_o, ((k % 2) == 0) ? 32'h300 : 32'h200);
                chk("rr_wdata", mem_wdata_o, ((k % 2) == 0) ? 32'h1122_3344 : 32'h0);
                chk("rr_be", {28'd0, mem_be_o}, ((k % 2) == 0) ? 32'h3 : 32'hF);
            end
            if (k > 0) begin
                chk("rr_drv", {31'd0, data_rvalid_o}, {31'd0, (k % 2) == 1});
                chk("rr_irv", {31'd0, instr_rvalid_o}, {31'd0, (k % 2) == 0});
            end
            tick();
        end

        // Lock on DATA for 3 stalled cycles, then INSTR next
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            chk("lk_req", {31'd0, mem_req_o}, 32'd1);
            chk("lk_addr", mem_addr_o, 32'h300);
            chk("lk_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("lk_addr4", mem_addr_o, 32'h300);
        chk("lk_dgnt", {31'd0, data_gnt_o}, 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("lk_next_i", {31'd0, instr_gnt_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lk_drv", {31'd0, data_rvalid_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lk_irv", {31'd0, instr_rvalid_o}, 32'd1);
        tick();

        // Lock on INSTR overrides round-robin preference for DATA
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("li_addr", mem_addr_o, 32'h200);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("li_hold_addr", mem_addr_o, 32'h200);
        chk("li_hold_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("li_gnt", {30'd0, instr_gnt_o, data_gnt_o}, 32'h2);
        tick();

        // Locked DATA drops its request: INSTR selected that cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_addr", mem_addr_o, 32'h300);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ld_addr2", mem_addr_o, 32'h200);
        chk("ld_igrant", {31'd0, instr_gnt_o}, 32'd1);
        tick();

        // Full: two outstanding, no grant even alongside a pop
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_req", {31'd0, mem_req_o}, 32'd0);
        chk("full_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("full_pop_req", {31'd0, mem_req_o}, 32'd0);
        chk("full_irv", {31'd0, instr_rvalid_o}, 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_req_back", {31'd0, mem_req_o}, 32'd1);
        chk("full_dgnt", {31'd0, data_gnt_o}, 32'd1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_again", {31'd0, mem_req_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("full_dr_i", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'h2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("full_dr_d", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'h1);
        tick();

        // Simultaneous push/pop at count 1 across pointer wrap
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pp_first", {31'd0, instr_gnt_o}, 32'd1);
        tick();
        prev = 1'b0;
        pat  = 10'b1011001010;
        for (int k = 0; k < 10; k++) begin
            p = pat[k];
            drive(!p, p, 1'b1, 1'b1);
            chk("pp_gnt", {30'd0, instr_gnt_o, data_gnt_o}, p ? 32'h1 : 32'h2);
            chk("pp_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, prev ? 32'h1 : 32'h2);
            tick();
            prev = p;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pp_last", {30'd0, instr_rvalid_o, data_rvalid_o}, prev ? 32'h1 : 32'h2);
        tick();

        // Spurious response with empty FIFO
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pe_before", {31'd0, proto_err_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pe_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pe_set", {31'd0, proto_err_o}, 32'd1);
        tick(); tick();
        chk("pe_hold", {31'd0, proto_err_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("pe_pre_rst", {31'd0, proto_err_o}, 32'd1);
        tick();
        chk("pe_clr", {31'd0, proto_err_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
